// File: rtl/drac_pkg.sv
// Shared types and constants for the load/store front end: FSM states,
// memory op/format encodings, dcache commands and RISC-V exception causes.
package drac_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    S1   = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } dcache_if_state_t;

  typedef enum logic [1:0] {
    MEM_LOAD  = 2'd0,
    MEM_STORE = 2'd1
  } mem_op_t;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } mem_format_t;

  localparam logic [4:0] M_XRD = 5'd0;
  localparam logic [4:0] M_XWR = 5'd1;

  localparam logic [3:0] CAUSE_MA_LD     = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS = 4'd5;
  localparam logic [3:0] CAUSE_MA_ST     = 4'd6;
  localparam logic [3:0] CAUSE_PF_LD     = 4'd13;
  localparam logic [3:0] CAUSE_PF_ST     = 4'd15;

  // Replicate the LSB lane of store data across the doubleword so the cache
  // can pick the lane selected by the byte address.
  function automatic logic [63:0] replicate_store(input mem_format_t fmt,
                                                  input logic [63:0] d);
    case (fmt)
      BYTE:    replicate_store = {8{d[7:0]}};
      HALF:    replicate_store = {4{d[15:0]}};
      WORD:    replicate_store = {2{d[31:0]}};
      default: replicate_store = d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load alignment: shift the raw doubleword right by the byte
// offset, then sign- or zero-extend from the access width.
module dmem_load_align
  import drac_pkg::*;
(
  input  mem_format_t fmt,
  input  logic        is_unsigned,
  input  logic [2:0]  offset,
  input  logic [63:0] raw,
  output logic [63:0] aligned
);

  logic [63:0] shifted;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;
  logic signed [31:0] lane_w;

  assign shifted = raw >> {offset, 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = shifted[15:0];
  assign lane_w  = shifted[31:0];

  // Extend the selected lane to 64 bits.
  always_comb begin
    aligned = shifted;
    case (fmt)
      BYTE:    aligned = is_unsigned ? {56'd0, lane_b} : 64'(lane_b);
      HALF:    aligned = is_unsigned ? {48'd0, lane_h} : 64'(lane_h);
      WORD:    aligned = is_unsigned ? {32'd0, lane_w} : 64'(lane_w);
      default: aligned = shifted;
    endcase
  end

endmodule

// File: rtl/dcache_interface.sv
// Blocking load/store front end between EXE and the data cache: one op in
// flight, reissue on nack, tag-filtered responses, exception reporting.
// Optional response watchdog enabled by defining DCACHE_TIMEOUT_EN.
module dcache_interface
  import drac_pkg::*;
#(
  parameter int TAG_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_op_i,
  input  logic [1:0]           req_format_i,
  input  logic                 req_unsigned_i,
  input  logic [39:0]          req_addr_i,
  input  logic [63:0]          req_data_i,
  input  logic [4:0]           req_rd_i,
  input  logic                 kill_i,
  output logic                 stall_o,
  output logic                 dmem_req_valid_o,
  input  logic                 dmem_req_ready_i,
  output logic [4:0]           dmem_req_cmd_o,
  output logic [39:0]          dmem_req_addr_o,
  output logic [1:0]           dmem_op_type_o,
  output logic [63:0]          dmem_req_data_o,
  output logic [TAG_WIDTH-1:0] dmem_req_tag_o,
  output logic                 dmem_req_kill_o,
  input  logic                 dmem_resp_valid_i,
  input  logic                 dmem_resp_replay_i,
  input  logic                 dmem_resp_nack_i,
  input  logic [TAG_WIDTH-1:0] dmem_resp_tag_i,
  input  logic [63:0]          dmem_resp_data_i,
  input  logic                 dmem_xcpt_ma_ld_i,
  input  logic                 dmem_xcpt_ma_st_i,
  input  logic                 dmem_xcpt_pf_ld_i,
  input  logic                 dmem_xcpt_pf_st_i,
  output logic                 resp_valid_o,
  output logic [4:0]           resp_rd_o,
  output logic [63:0]          resp_data_o,
  output logic                 xcpt_valid_o,
  output logic [3:0]           xcpt_cause_o
);

  dcache_if_state_t     state_q;
  mem_op_t              op_q;
  mem_format_t          fmt_q;
  logic                 uns_q;
  logic [39:0]          addr_q;
  logic [63:0]          data_q;
  logic [4:0]           rd_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [63:0]          load_data;
  logic                 any_xcpt;
  logic [3:0]           cause;
  logic                 resp_hit;

`ifdef DCACHE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
`else
  // No watchdog: WAIT holds until a matching response, a nack or a kill.
`endif

  dmem_load_align u_align (
    .fmt         (fmt_q),
    .is_unsigned (uns_q),
    .offset      (addr_q[2:0]),
    .raw         (dmem_resp_data_i),
    .aligned     (load_data)
  );

  assign any_xcpt = dmem_xcpt_ma_ld_i | dmem_xcpt_ma_st_i |
                    dmem_xcpt_pf_ld_i | dmem_xcpt_pf_st_i;
  assign resp_hit = (dmem_resp_valid_i | dmem_resp_replay_i) &&
                    (dmem_resp_tag_i == tag_q);

  // Misaligned faults win over page faults.
  always_comb begin
    cause = CAUSE_PF_ST;
    if (dmem_xcpt_ma_ld_i)      cause = CAUSE_MA_LD;
    else if (dmem_xcpt_ma_st_i) cause = CAUSE_MA_ST;
    else if (dmem_xcpt_pf_ld_i) cause = CAUSE_PF_LD;
  end

  assign req_ready_o      = (state_q == IDLE);
  assign stall_o          = ((state_q == IDLE) && req_valid_i) ||
                            (state_q == REQ) || (state_q == S1) || (state_q == WAIT);
  assign dmem_req_valid_o = (state_q == REQ);
  assign dmem_req_cmd_o   = (op_q == MEM_STORE) ? M_XWR : M_XRD;
  assign dmem_req_addr_o  = addr_q;
  assign dmem_op_type_o   = fmt_q;
  assign dmem_req_data_o  = replicate_store(fmt_q, data_q);
  assign dmem_req_tag_o   = tag_q;
  assign dmem_req_kill_o  = (state_q == S1) && kill_i && !rst_i;

  // Operation FSM with registered completion/exception outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      op_q         <= MEM_LOAD;
      fmt_q        <= BYTE;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      rd_q         <= '0;
      tag_q        <= '0;
      resp_valid_o <= 1'b0;
      resp_rd_o    <= '0;
      resp_data_o  <= '0;
      xcpt_valid_o <= 1'b0;
      xcpt_cause_o <= '0;
`ifdef DCACHE_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      resp_valid_o <= 1'b0;
      xcpt_valid_o <= 1'b0;
      case (state_q)
        IDLE: if (req_valid_i) begin
          op_q    <= mem_op_t'(req_op_i);
          fmt_q   <= mem_format_t'(req_format_i);
          uns_q   <= req_unsigned_i;
          addr_q  <= req_addr_i;
          data_q  <= req_data_i;
          rd_q    <= req_rd_i;
          tag_q   <= tag_q + 1'b1;
          state_q <= REQ;
        end
        REQ: begin
          if (kill_i)                state_q <= IDLE;
          else if (dmem_req_ready_i) state_q <= S1;
        end
        S1: begin
          if (kill_i) begin
            state_q <= IDLE;
          end else if (any_xcpt) begin
            state_q      <= DONE;
            resp_valid_o <= 1'b1;
            resp_rd_o    <= rd_q;
            resp_data_o  <= '0;
            xcpt_valid_o <= 1'b1;
            xcpt_cause_o <= cause;
          end else if (dmem_resp_nack_i) begin
            state_q <= REQ;
          end else if (op_q == MEM_STORE) begin
            state_q      <= DONE;
            resp_valid_o <= 1'b1;
            resp_rd_o    <= rd_q;
            resp_data_o  <= '0;
          end else begin
            state_q <= WAIT;
`ifdef DCACHE_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        WAIT: begin
          if (kill_i) begin
            state_q <= IDLE;
          end else if (resp_hit) begin
            state_q      <= DONE;
            resp_valid_o <= 1'b1;
            resp_rd_o    <= rd_q;
            resp_data_o  <= load_data;
          end else if (dmem_resp_nack_i) begin
            state_q <= REQ;
`ifdef DCACHE_TIMEOUT_EN
          end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_q      <= DONE;
            resp_valid_o <= 1'b1;
            resp_rd_o    <= rd_q;
            resp_data_o  <= '0;
            xcpt_valid_o <= 1'b1;
            xcpt_cause_o <= CAUSE_LD_ACCESS;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_interface.sv
// Directed bench for dcache_interface: alignment/extension, store lane
// replication, nack reissue, kill with stale response, exceptions, reset.
module tb_dcache_interface;
  import drac_pkg::*;

`ifdef DCACHE_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_unsigned, kill, stall;
  logic [1:0]  req_op, req_format, dmem_op_type;
  logic [39:0] req_addr, dmem_req_addr;
  logic [63:0] req_data, dmem_req_data, dmem_resp_data, resp_data;
  logic [4:0]  req_rd, dmem_req_cmd, resp_rd;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_kill;
  logic [7:0]  dmem_req_tag, dmem_resp_tag;
  logic        dmem_resp_valid, dmem_resp_replay, dmem_resp_nack;
  logic        ma_ld, ma_st, pf_ld, pf_st;
  logic        resp_valid, xcpt_valid;
  logic [3:0]  xcpt_cause;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_tag = 8'd0;
  int         n_req;
  logic [7:0] old_tag;

  dcache_interface #(.TAG_WIDTH(8), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_format_i(req_format), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_rd_i(req_rd), .kill_i(kill), .stall_o(stall),
    .dmem_req_valid_o(dmem_req_valid), .dmem_req_ready_i(dmem_req_ready),
    .dmem_req_cmd_o(dmem_req_cmd), .dmem_req_addr_o(dmem_req_addr),
    .dmem_op_type_o(dmem_op_type), .dmem_req_data_o(dmem_req_data),
    .dmem_req_tag_o(dmem_req_tag), .dmem_req_kill_o(dmem_req_kill),
    .dmem_resp_valid_i(dmem_resp_valid), .dmem_resp_replay_i(dmem_resp_replay),
    .dmem_resp_nack_i(dmem_resp_nack), .dmem_resp_tag_i(dmem_resp_tag),
    .dmem_resp_data_i(dmem_resp_data),
    .dmem_xcpt_ma_ld_i(ma_ld), .dmem_xcpt_ma_st_i(ma_st),
    .dmem_xcpt_pf_ld_i(pf_ld), .dmem_xcpt_pf_st_i(pf_st),
    .resp_valid_o(resp_valid), .resp_rd_o(resp_rd), .resp_data_o(resp_data),
    .xcpt_valid_o(xcpt_valid), .xcpt_cause_o(xcpt_cause)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle in IDLE; the DUT accepts it at the edge.
  task automatic accept(input logic [1:0] op, input logic [1:0] fmt, input logic uns,
                        input logic [39:0] addr, input logic [63:0] data, input logic [4:0] rd);
    req_valid = 1'b1; req_op = op; req_format = fmt; req_unsigned = uns;
    req_addr = addr; req_data = data; req_rd = rd;
    tick();
    req_valid = 1'b0;
    exp_tag = exp_tag + 8'd1;
  endtask

  // Immediate ready, then a response in the first WAIT cycle (4-cycle load).
  task automatic do_load(input string nm, input logic [1:0] fmt, input logic uns,
                         input logic [39:0] addr, input logic [63:0] raw,
                         input logic [63:0] exp);
    accept(MEM_LOAD, fmt, uns, addr, 64'h0, 5'd9);
    check_eq({nm, "_tag"}, dmem_req_tag, exp_tag);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    tick();
    dmem_resp_valid = 1'b1; dmem_resp_tag = exp_tag; dmem_resp_data = raw;
    check_eq({nm, "_pre"}, resp_valid, 1'b0);
    tick();
    dmem_resp_valid = 1'b0;
    check_eq({nm, "_vld"}, resp_valid, 1'b1);
    check_eq({nm, "_data"}, resp_data, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 0; req_op = 0; req_format = 0; req_unsigned = 0;
    req_addr = 0; req_data = 0; req_rd = 0; kill = 0; dmem_req_ready = 0;
    dmem_resp_valid = 0; dmem_resp_replay = 0; dmem_resp_nack = 0;
    dmem_resp_tag = 0; dmem_resp_data = 0; ma_ld = 0; ma_st = 0; pf_ld = 0; pf_st = 0;
    tick(); tick();
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_req_valid", dmem_req_valid, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_tag", dmem_req_tag, 8'd0);
    check_eq("rst_xcpt", xcpt_valid, 1'b0);
    check_eq("rst_ready", req_ready, 1'b1);
    rst = 1'b0;
    tick();

    // LB / LBU from byte 3, LH from byte 6, LD unchanged.
    req_valid = 1'b1; #1;
    check_eq("idle_stall", stall, 1'b1);
    req_valid = 1'b0;
    do_load("lb",  BYTE,  1'b0, 40'h00_0000_1003, 64'h1122_3344_F055_6677, 64'hFFFF_FFFF_FFFF_FFF0);
    do_load("lbu", BYTE,  1'b1, 40'h00_0000_1003, 64'h1122_3344_F055_6677, 64'h0000_0000_0000_00F0);
    do_load("lh",  HALF,  1'b0, 40'h00_0000_2006, 64'h9ABC_0000_0000_0000, 64'hFFFF_FFFF_FFFF_9ABC);
    do_load("lhu", HALF,  1'b1, 40'h00_0000_2006, 64'h9ABC_0000_0000_0000, 64'h0000_0000_0000_9ABC);
    do_load("ld",  DWORD, 1'b0, 40'h00_0000_3000, 64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211);

    // SH with ready two cycles late: resp_valid 5 cycles after accept.
    accept(MEM_STORE, HALF, 1'b0, 40'h00_0000_4002, 64'hDEAD_BEEF_CAFE_1234, 5'd3);
    check_eq("sh_data", dmem_req_data, 64'h1234_1234_1234_1234);
    check_eq("sh_cmd", dmem_req_cmd, M_XWR);
    check_eq("sh_type", dmem_op_type, HALF);
    tick();
    tick();
    check_eq("sh_hold", dmem_req_valid, 1'b1);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    check_eq("sh_s1_vld", dmem_req_valid, 1'b0);
    check_eq("sh_s1_resp", resp_valid, 1'b0);
    tick();
    check_eq("sh_done", resp_valid, 1'b1);
    check_eq("sh_rdata", resp_data, 64'h0);
    check_eq("sh_stall", stall, 1'b0);
    tick();
    check_eq("sh_pulse", resp_valid, 1'b0);

    // LW nacked twice in S1: three requests with the same tag, one response.
    accept(MEM_LOAD, WORD, 1'b0, 40'h00_0000_5004, 64'h0, 5'd7);
    n_req = 0;
    for (int n = 0; n < 3; n++) begin
      check_eq("lw_retag", dmem_req_tag, exp_tag);
      if (dmem_req_valid) n_req++;
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      if (n < 2) begin
        dmem_resp_nack = 1'b1;
        tick();
        dmem_resp_nack = 1'b0;
      end
    end
    tick();
    dmem_resp_valid = 1'b1; dmem_resp_tag = exp_tag; dmem_resp_data = 64'h8000_0001_0000_0000;
    tick();
    dmem_resp_valid = 1'b0;
    check_eq("lw_nreq", n_req, 3);
    check_eq("lw_vld", resp_valid, 1'b1);
    check_eq("lw_data", resp_data, 64'hFFFF_FFFF_8000_0001);
    check_eq("lw_rd", resp_rd, 5'd7);
    tick();
    check_eq("lw_once", resp_valid, 1'b0);

    // LD killed in WAIT, then a new LD; stale response must be ignored.
    accept(MEM_LOAD, DWORD, 1'b0, 40'h00_0000_6000, 64'h0, 5'd1);
    old_tag = exp_tag;
    dmem_req_ready = 1'b1; tick(); dmem_req_ready = 1'b0; tick();
    kill = 1'b1; tick(); kill = 1'b0;
    check_eq("kill_idle", req_ready, 1'b1);
    check_eq("kill_resp", resp_valid, 1'b0);
    accept(MEM_LOAD, DWORD, 1'b0, 40'h00_0000_6008, 64'h0, 5'd2);
    check_eq("kill_newtag", dmem_req_tag, old_tag + 8'd1);
    dmem_req_ready = 1'b1; tick(); dmem_req_ready = 1'b0; tick();
    dmem_resp_valid = 1'b1; dmem_resp_tag = old_tag; dmem_resp_data = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    check_eq("stale_ign", resp_valid, 1'b0);
    check_eq("stale_stall", stall, 1'b1);
    dmem_resp_tag = exp_tag; dmem_resp_data = 64'h0123_4567_89AB_CDEF;
    tick();
    dmem_resp_valid = 1'b0;
    check_eq("new_vld", resp_valid, 1'b1);
    check_eq("new_data", resp_data, 64'h0123_4567_89AB_CDEF);
    tick();

    // Store with ma_st and pf_st together: misaligned wins (cause 6).
    accept(MEM_STORE, WORD, 1'b0, 40'h00_0000_7001, 64'h55, 5'd4);
    dmem_req_ready = 1'b1; tick(); dmem_req_ready = 1'b0;
    ma_st = 1'b1; pf_st = 1'b1;
    tick();
    ma_st = 1'b0; pf_st = 1'b0;
    check_eq("xst_vld", xcpt_valid, 1'b1);
    check_eq("xst_cause", xcpt_cause, 4'd6);
    tick();
    check_eq("xst_clr", xcpt_valid, 1'b0);

    // Load page fault in S1: cause 13.
    accept(MEM_LOAD, WORD, 1'b0, 40'h00_0000_8000, 64'h0, 5'd5);
    dmem_req_ready = 1'b1; tick(); dmem_req_ready = 1'b0;
    pf_ld = 1'b1; tick(); pf_ld = 1'b0;
    check_eq("xld_cause", xcpt_cause, 4'd13);
    check_eq("xld_vld", xcpt_valid, 1'b1);
    tick();

    // Kill in S1 drives dmem_req_kill_o and returns to IDLE.
    accept(MEM_STORE, BYTE, 1'b0, 40'h00_0000_9000, 64'hAB, 5'd6);
    check_eq("sb_data", dmem_req_data, 64'hABAB_ABAB_ABAB_ABAB);
    dmem_req_ready = 1'b1; tick(); dmem_req_ready = 1'b0;
    kill = 1'b1; #1;
    check_eq("s1_kill_o", dmem_req_kill, 1'b1);
    tick(); kill = 1'b0;
    check_eq("s1_kill_idle", req_ready, 1'b1);
    check_eq("s1_kill_resp", resp_valid, 1'b0);
    check_eq("kill_o_clr", dmem_req_kill, 1'b0);

    // Reset while a request is outstanding.
    accept(MEM_LOAD, WORD, 1'b0, 40'h00_0000_A000, 64'h0, 5'd8);
    check_eq("mid_req", dmem_req_valid, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    exp_tag = 8'd0;
    check_eq("mid_rst_vld", dmem_req_valid, 1'b0);
    check_eq("mid_rst_kill", dmem_req_kill, 1'b0);
    check_eq("mid_rst_tag", dmem_req_tag, exp_tag);
    check_eq("mid_rst_stall", stall, 1'b0);
    do_load("post_rst", WORD, 1'b1, 40'h00_0000_B004, 64'hF000_0000_1111_1111, 64'h0000_0000_F000_0000);

`ifdef DCACHE_TIMEOUT_EN
    // No response: the watchdog completes the load with cause 5.
    accept(MEM_LOAD, DWORD, 1'b0, 40'h00_0000_C000, 64'h0, 5'd10);
    dmem_req_ready = 1'b1; tick(); dmem_req_ready = 1'b0; tick();
    n_req = 0;
    while (!resp_valid && n_req < 20) begin
      tick();
      n_req++;
    end
    check_eq("to_cycles", n_req, 4);
    check_eq("to_xcpt", xcpt_valid, 1'b1);
    check_eq("to_cause", xcpt_cause, 4'd5);
    check_eq("to_stall", stall, 1'b0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
